// File: rtl/ddr3_app_pkg.sv
// rtl/ddr3_app_pkg.sv - shared constants and types for the DDR3 app-side request controller
//
// Purpose: MIG command encodings, default widths and the controller state enum.
// Ports:   none (package).

package ddr3_app_pkg;

  localparam int ADDR_W_DEF    = 28;
  localparam int DATA_W_DEF    = 512;
  localparam int RSP_DEPTH_DEF = 8;

  // MIG native app_cmd encodings
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_e;

endpackage

// File: rtl/ddr3_app_ctrl_if.sv
// rtl/ddr3_app_ctrl_if.sv - request/response and MIG app_* bundle for ddr3_app_ctrl
//
// Purpose: groups the user request port, the read response port and the MIG
//          native interface into one bundle.
// Modports:
//   slave  - the controller: takes requests, returns responses, drives app_*
//   master - the environment: user logic plus the MIG wrapper
// Signals:
//   req_valid/req_ready/req_write/req_addr/req_data/req_mask  user request
//   rsp_valid/rsp_ready/rsp_data                              read response
//   app_addr/app_cmd/app_en/app_rdy                           MIG command
//   app_wdf_data/app_wdf_mask/app_wdf_wren/app_wdf_end/app_wdf_rdy  MIG write data
//   app_rd_data/app_rd_data_valid/app_rd_data_end             MIG read data

interface ddr3_app_ctrl_if
  import ddr3_app_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_data;
  logic [DATA_W/8-1:0]   req_mask;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_data;

  logic [ADDR_W-1:0]     app_addr;
  logic [2:0]            app_cmd;
  logic                  app_en;
  logic [DATA_W-1:0]     app_wdf_data;
  logic [DATA_W/8-1:0]   app_wdf_mask;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic                  app_rdy;
  logic                  app_wdf_rdy;
  logic [DATA_W-1:0]     app_rd_data;
  logic                  app_rd_data_valid;
  logic                  app_rd_data_end;

  modport slave (
    input  req_valid, req_write, req_addr, req_data, req_mask,
    input  rsp_ready,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
    output req_ready, rsp_valid, rsp_data,
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );

  modport master (
    output req_valid, req_write, req_addr, req_data, req_mask,
    output rsp_ready,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
    input  req_ready, rsp_valid, rsp_data,
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );

endinterface

// File: rtl/ddr3_rsp_fifo.sv
// rtl/ddr3_rsp_fifo.sv - synchronous first-word-fall-through FIFO for MIG read data
//
// Purpose: buffers read data that the MIG cannot stall; head entry is always
//          visible on pop_data_o while valid_o is high.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   push_i, push_data_i write side (a push while full is dropped)
//   pop_i               consume head entry when valid_o
//   pop_data_o, valid_o head entry and non-empty flag
//   count_o             current occupancy

module ddr3_rsp_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             valid_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && (count_q != '0);

  assign pop_data_o = mem_q[rd_ptr_q];
  assign valid_o    = (count_q != '0);
  assign count_o    = count_q;

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push_i && full)) else $error("ddr3_rsp_fifo: push while full, data dropped");
    end
  end
`endif

endmodule

// File: rtl/ddr3_app_ctrl.sv
// rtl/ddr3_app_ctrl.sv - single-beat request sequencer driving the DDR3 MIG app_* interface
//
// Purpose: accepts one 512-bit read or write at a time, strobes app_en and
//          app_wdf_wren independently until the MIG takes each, and returns
//          read data in order through a response FIFO. Reads are credit-gated
//          so the non-stallable MIG read data always has a free FIFO slot.
// Ports:
//   ui_clk               MIG user clock
//   ui_clk_sync_rst      synchronous active-high reset
//   init_calib_complete  new requests are accepted only once calibration is done
//   bus (slave)          request, response and MIG app_* signals

module ddr3_app_ctrl
  import ddr3_app_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
  input  logic           ui_clk,
  input  logic           ui_clk_sync_rst,
  input  logic           init_calib_complete,
  ddr3_app_ctrl_if.slave bus
);

  localparam int MW  = DATA_W / 8;
  localparam int CRW = $clog2(RSP_DEPTH + 1);

  state_e            state_q,   state_d;
  logic              app_en_q,  app_en_d;
  logic              wren_q,    wren_d;
  logic [2:0]        cmd_q,     cmd_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] data_q,    data_d;
  logic [MW-1:0]     mask_q,    mask_d;
  logic [CRW-1:0]    credits_q, credits_d;

  logic              req_ready;
  logic              accept;
  logic              pop;
  logic              en_done;
  logic              wdf_done;
  logic              fifo_valid;
  logic [DATA_W-1:0] fifo_data;
  logic [CRW-1:0]    fifo_count;

  // Reset gating keeps req_ready low while reset is held even though the
  // state register already reads IDLE.
  assign req_ready = !ui_clk_sync_rst && (state_q == ST_IDLE) && init_calib_complete
                     && (credits_q < CRW'(RSP_DEPTH));
  assign accept    = bus.req_valid && req_ready;
  assign pop       = fifo_valid && bus.rsp_ready;

  // A strobe counts as done if it already dropped or is being taken this cycle.
  assign en_done   = !app_en_q || bus.app_rdy;
  assign wdf_done  = !wren_q || bus.app_wdf_rdy;

  always_comb begin
    state_d   = state_q;
    app_en_d  = app_en_q;
    wren_d    = wren_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    mask_d    = mask_q;
    credits_d = credits_q + CRW'(accept && !bus.req_write) - CRW'(pop);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d   = bus.req_addr;
          data_d   = bus.req_data;
          mask_d   = bus.req_mask;
          app_en_d = 1'b1;
          if (bus.req_write) begin
            cmd_d   = CMD_WRITE;
            wren_d  = 1'b1;
            state_d = ST_WR;
          end else begin
            cmd_d   = CMD_READ;
            state_d = ST_RD;
          end
        end
      end
      ST_WR: begin
        if (app_en_q && bus.app_rdy)    app_en_d = 1'b0;
        if (wren_q && bus.app_wdf_rdy)  wren_d   = 1'b0;
        if (en_done && wdf_done)        state_d  = ST_IDLE;
      end
      ST_RD: begin
        if (bus.app_rdy) begin
          app_en_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state_q   <= ST_IDLE;
      app_en_q  <= 1'b0;
      wren_q    <= 1'b0;
      cmd_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      credits_q <= '0;
    end else begin
      state_q   <= state_d;
      app_en_q  <= app_en_d;
      wren_q    <= wren_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      credits_q <= credits_d;
    end
  end

  ddr3_rsp_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i       (ui_clk),
    .rst_i       (ui_clk_sync_rst),
    .push_i      (bus.app_rd_data_valid),
    .push_data_i (bus.app_rd_data),
    .pop_i       (pop),
    .pop_data_o  (fifo_data),
    .valid_o     (fifo_valid),
    .count_o     (fifo_count)
  );

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = fifo_valid;
  assign bus.rsp_data     = fifo_data;
  assign bus.app_addr     = addr_q;
  assign bus.app_cmd      = cmd_q;
  assign bus.app_en       = app_en_q;
  assign bus.app_wdf_data = data_q;
  assign bus.app_wdf_mask = mask_q;
  assign bus.app_wdf_wren = wren_q;
  assign bus.app_wdf_end  = wren_q;

`ifndef SYNTHESIS
  // Every buffered beat belongs to a read still holding a credit.
  always_ff @(posedge ui_clk) begin
    if (!ui_clk_sync_rst) begin
      assert (fifo_count <= credits_q) else $error("ddr3_app_ctrl: buffered reads exceed credits");
      assert (credits_q <= CRW'(RSP_DEPTH)) else $error("ddr3_app_ctrl: credit overflow");
    end
  end
`endif

endmodule

// File: tb/tb_ddr3_app_ctrl.sv
// tb/tb_ddr3_app_ctrl.sv - self-checking bench for ddr3_app_ctrl

module tb_ddr3_app_ctrl;
  import ddr3_app_pkg::*;

  localparam int AW    = 28;
  localparam int DW    = 512;
  localparam int MW    = DW / 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  logic calib;
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ddr3_app_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ddr3_app_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(DEPTH)) dut (
    .ui_clk              (clk),
    .ui_clk_sync_rst     (rst),
    .init_calib_complete (calib),
    .bus                 (bus)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } req_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_data = '0; bus.req_mask = '0;
    bus.rsp_ready = 0; bus.app_rdy = 0; bus.app_wdf_rdy = 0;
    bus.app_rd_data = '0; bus.app_rd_data_valid = 0; bus.app_rd_data_end = 0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Read data the MIG model returns for a given address.
  function automatic logic [DW-1:0] rd_pattern(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = {4'(i), a};
    return d;
  endfunction

  task automatic issue_req(input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [MW-1:0] m);
    int w = 0;
    while (!bus.req_ready && w < 50) begin tick(); w++; end
    if (!bus.req_ready) begin
      n_cmp++; n_err++;
      $display("FAIL issue_timeout: req_ready got 0 want 1");
    end
    bus.req_valid = 1; bus.req_write = wr; bus.req_addr = a; bus.req_data = d; bus.req_mask = m;
    tick();
    bus.req_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      calib = 1'($urandom); bus.req_valid = 1'($urandom); bus.req_write = 1'($urandom);
      bus.req_addr = AW'($urandom); bus.req_data = rand_data(); bus.req_mask = {$urandom, $urandom};
      bus.rsp_ready = 1'($urandom); bus.app_rdy = 1'($urandom); bus.app_wdf_rdy = 1'($urandom);
      bus.app_rd_data = rand_data(); bus.app_rd_data_valid = 1'($urandom);
      bus.app_rd_data_end = bus.app_rd_data_valid;
      tick();
    end
    calib = 1;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); end
    n_cmp++; if (bus.app_en !== 1'b0) begin n_err++; $display("FAIL rst_app_en: got %b want 0", bus.app_en); end
    n_cmp++; if (bus.app_wdf_wren !== 1'b0 || bus.app_wdf_end !== 1'b0) begin n_err++; $display("FAIL rst_wren_end: got %b%b want 00", bus.app_wdf_wren, bus.app_wdf_end); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.app_cmd !== 3'b000) begin n_err++; $display("FAIL rst_app_cmd: got %b want 000", bus.app_cmd); end
    n_cmp++; if (bus.app_addr !== '0 || bus.app_wdf_data !== '0 || bus.app_wdf_mask !== '0) begin n_err++; $display("FAIL rst_payload: addr %h mask %h want 0", bus.app_addr, bus.app_wdf_mask); end
    idle_inputs();
    rst = 0;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", bus.req_ready); end
  endtask

  // Write with the MIG taking the command after en_dly and the data after wdf_dly cycles.
  task automatic test_write(input int en_dly, input int wdf_dly,
                            input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    int en_cnt = 0, wr_cnt = 0, ready_k = -1, bad = 0;
    bus.app_rdy = 0; bus.app_wdf_rdy = 0;
    bus.req_valid = 1; bus.req_write = 1; bus.req_addr = a; bus.req_data = d; bus.req_mask = m;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL wr_accept_ready: got %b want 1", bus.req_ready); end
    tick();
    bus.req_valid = 0;
    for (int k = 1; k <= 12; k++) begin
      if (bus.app_en) begin
        en_cnt++;
        if (bus.app_cmd !== CMD_WRITE || bus.app_addr !== a) bad++;
      end
      if (bus.app_wdf_wren) begin
        wr_cnt++;
        if (bus.app_wdf_data !== d || bus.app_wdf_mask !== m) bad++;
      end
      if (bus.app_wdf_end !== bus.app_wdf_wren) bad++;
      if (bus.req_ready && ready_k < 0) ready_k = k;
      bus.app_rdy     = (k > en_dly);
      bus.app_wdf_rdy = (k > wdf_dly);
      tick();
    end
    n_cmp++; if (en_cnt != en_dly + 1) begin n_err++; $display("FAIL wr_app_en_cycles: got %0d want %0d", en_cnt, en_dly + 1); end
    n_cmp++; if (wr_cnt != wdf_dly + 1) begin n_err++; $display("FAIL wr_wren_cycles: got %0d want %0d", wr_cnt, wdf_dly + 1); end
    n_cmp++; if (ready_k != ((en_dly > wdf_dly) ? en_dly : wdf_dly) + 2) begin n_err++; $display("FAIL wr_ready_return: got %0d want %0d", ready_k, ((en_dly > wdf_dly) ? en_dly : wdf_dly) + 2); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL wr_payload: got %0d bad cycles want 0", bad); end
    idle_inputs();
  endtask

  task automatic test_read();
    logic [DW-1:0] d = {16{32'hA5A5A5A5}};
    bus.app_rdy = 1;
    issue_req(1'b0, 28'h0000040, '0, '0);
    n_cmp++; if (bus.app_en !== 1'b1 || bus.app_cmd !== CMD_READ || bus.app_addr !== 28'h0000040) begin n_err++; $display("FAIL rd_cmd: got en %b cmd %b addr %h want 1 001 0000040", bus.app_en, bus.app_cmd, bus.app_addr); end
    tick();
    n_cmp++; if (bus.app_en !== 1'b0 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rd_done: got en %b ready %b want 0 1", bus.app_en, bus.req_ready); end
    for (int k = 2; k < 10; k++) tick();
    bus.app_rd_data = d; bus.app_rd_data_valid = 1; bus.app_rd_data_end = 1;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_rsp_early: got %b want 0", bus.rsp_valid); end
    tick();
    bus.app_rd_data_valid = 0; bus.app_rd_data_end = 0; bus.app_rd_data = '0;
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d) begin n_err++; $display("FAIL rd_rsp: got valid %b data %h want 1 %h", bus.rsp_valid, bus.rsp_data, d); end
    bus.rsp_ready = 1;
    tick();
    bus.rsp_ready = 0;
    n_cmp++; if (bus.rsp_valid !== 1'b0 || dut.credits_q !== '0) begin n_err++; $display("FAIL rd_pop: got valid %b credits %0d want 0 0", bus.rsp_valid, dut.credits_q); end
    idle_inputs();
  endtask

  task automatic test_credit_limit();
    logic [AW-1:0] a [DEPTH];
    int bad = 0;
    bus.app_rdy = 1;
    for (int i = 0; i < DEPTH; i++) begin
      a[i] = AW'($urandom);
      issue_req(1'b0, a[i], '0, '0);
    end
    tick();
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL credit_full_ready: got %b want 0", bus.req_ready); end
    bus.req_valid = 1; bus.req_write = 0; bus.req_addr = AW'($urandom);
    for (int i = 0; i < DEPTH; i++) begin
      bus.app_rd_data = rd_pattern(a[i]); bus.app_rd_data_valid = 1; bus.app_rd_data_end = 1;
      tick();
      if (bus.app_en !== 1'b0) bad++;
    end
    bus.app_rd_data_valid = 0; bus.app_rd_data_end = 0; bus.req_valid = 0;
    tick();
    n_cmp++; if (bad != 0 || bus.app_en !== 1'b0) begin n_err++; $display("FAIL credit_blocked_cmd: got %0d app_en cycles want 0", bad); end
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== rd_pattern(a[0]) || bus.req_ready !== 1'b0) begin n_err++; $display("FAIL credit_head: got valid %b ready %b data %h want 1 0 %h", bus.rsp_valid, bus.req_ready, bus.rsp_data, rd_pattern(a[0])); end
    bus.rsp_ready = 1;
    tick();
    bus.rsp_ready = 0;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL credit_release_ready: got %b want 1", bus.req_ready); end
    for (int i = 1; i < DEPTH; i++) begin
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== rd_pattern(a[i])) begin n_err++; $display("FAIL credit_order_%0d: got valid %b data %h want 1 %h", i, bus.rsp_valid, bus.rsp_data, rd_pattern(a[i])); end
      bus.rsp_ready = 1;
      tick();
      bus.rsp_ready = 0;
    end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL credit_drained: got %b want 0", bus.rsp_valid); end
    idle_inputs();
  endtask

  task automatic test_calib();
    int bad = 0;
    calib = 0;
    bus.app_rdy = 1; bus.app_wdf_rdy = 1;
    bus.req_valid = 1; bus.req_write = 1; bus.req_addr = AW'($urandom); bus.req_data = rand_data();
    #1;
    for (int i = 0; i < 5; i++) begin
      if (bus.req_ready !== 1'b0 || bus.app_en !== 1'b0) bad++;
      tick();
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL calib_blocked: got %0d cycles with ready/app_en want 0", bad); end
    calib = 1;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL calib_ready: got %b want 1", bus.req_ready); end
    tick();
    bus.req_valid = 0;
    n_cmp++; if (bus.app_en !== 1'b1 || bus.app_wdf_wren !== 1'b1) begin n_err++; $display("FAIL calib_accept: got en %b wren %b want 1 1", bus.app_en, bus.app_wdf_wren); end
    tick(); tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_wr();
    bus.app_rdy = 1;
    issue_req(1'b0, AW'($urandom), '0, '0);
    tick();
    bus.app_rdy = 0; bus.app_wdf_rdy = 0;
    issue_req(1'b1, AW'($urandom), rand_data(), '0);
    tick();
    n_cmp++; if (dut.state_q !== ST_WR || bus.app_en !== 1'b1 || bus.app_wdf_wren !== 1'b1) begin n_err++; $display("FAIL midwr_busy: got state %0d en %b wren %b want WR 1 1", dut.state_q, bus.app_en, bus.app_wdf_wren); end
    rst = 1;
    tick();
    n_cmp++; if (bus.app_en !== 1'b0 || bus.app_wdf_wren !== 1'b0) begin n_err++; $display("FAIL midwr_strobes: got en %b wren %b want 0 0", bus.app_en, bus.app_wdf_wren); end
    n_cmp++; if (dut.state_q !== ST_IDLE || dut.credits_q !== '0 || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL midwr_state: got state %0d credits %0d rsp %b want IDLE 0 0", dut.state_q, dut.credits_q, bus.rsp_valid); end
    rst = 0;
    idle_inputs();
    tick();
  endtask

  // Random traffic against a queue-based model of the request/response contract.
  task automatic test_random();
    localparam int NREQ = 200;
    localparam int BOUND = 20000;
    req_t          exp_cmd[$];
    req_t          exp_wdf[$];
    logic [AW-1:0] exp_rsp[$];
    int            ret_due[$];
    logic [AW-1:0] ret_addr[$];
    int cyc = 0, issued = 0, outstanding = 0, last_due = 0, n_reads = 0, n_rsps = 0;
    logic exp_ready;
    req_t r, h;
    while (cyc < BOUND && !(issued == NREQ && exp_cmd.size() == 0 && exp_wdf.size() == 0
                            && outstanding == 0 && ret_due.size() == 0)) begin
      exp_ready = (exp_cmd.size() == 0) && (exp_wdf.size() == 0) && (outstanding < DEPTH);
      n_cmp++; if (bus.req_ready !== exp_ready) begin n_err++; $display("FAIL rnd_req_ready@%0d: got %b want %b", cyc, bus.req_ready, exp_ready); end
      n_cmp++; if (bus.app_wdf_end !== bus.app_wdf_wren) begin n_err++; $display("FAIL rnd_wdf_end@%0d: got %b want %b", cyc, bus.app_wdf_end, bus.app_wdf_wren); end

      bus.req_valid = (issued < NREQ) && ($urandom_range(0, 2) != 0);
      bus.req_write = 1'($urandom);
      bus.req_addr  = AW'($urandom);
      bus.req_data  = rand_data();
      bus.req_mask  = {$urandom, $urandom};
      bus.app_rdy     = ($urandom_range(0, 3) != 0);
      bus.app_wdf_rdy = ($urandom_range(0, 2) != 0);
      bus.rsp_ready   = ($urandom_range(0, 99) < 40);
      if (ret_due.size() != 0 && ret_due[0] <= cyc) begin
        void'(ret_due.pop_front());
        bus.app_rd_data = rd_pattern(ret_addr.pop_front());
        bus.app_rd_data_valid = 1;
      end else begin
        bus.app_rd_data = rand_data();
        bus.app_rd_data_valid = 0;
      end
      bus.app_rd_data_end = bus.app_rd_data_valid;

      if (bus.app_en && bus.app_rdy) begin
        if (exp_cmd.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL rnd_unexpected_cmd@%0d: got cmd %b want none", cyc, bus.app_cmd);
        end else begin
          h = exp_cmd.pop_front();
          n_cmp++; if (bus.app_cmd !== (h.wr ? CMD_WRITE : CMD_READ) || bus.app_addr !== h.addr) begin n_err++; $display("FAIL rnd_cmd@%0d: got %b/%h want %b/%h", cyc, bus.app_cmd, bus.app_addr, h.wr ? CMD_WRITE : CMD_READ, h.addr); end
          if (!h.wr) begin
            last_due = ((cyc + 1 + $urandom_range(0, 6)) > last_due + 1) ? (cyc + 1 + $urandom_range(0, 6)) : last_due + 1;
            ret_due.push_back(last_due);
            ret_addr.push_back(h.addr);
          end
        end
      end
      if (bus.app_wdf_wren && bus.app_wdf_rdy) begin
        if (exp_wdf.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL rnd_unexpected_wdf@%0d: got wren 1 want 0", cyc);
        end else begin
          h = exp_wdf.pop_front();
          n_cmp++; if (bus.app_wdf_data !== h.data || bus.app_wdf_mask !== h.mask) begin n_err++; $display("FAIL rnd_wdf@%0d: got mask %h want %h", cyc, bus.app_wdf_mask, h.mask); end
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL rnd_unexpected_rsp@%0d: got rsp_valid 1 want 0", cyc);
        end else begin
          n_cmp++; if (bus.rsp_data !== rd_pattern(exp_rsp[0])) begin n_err++; $display("FAIL rnd_rsp@%0d: got %h want %h", cyc, bus.rsp_data, rd_pattern(exp_rsp[0])); end
          void'(exp_rsp.pop_front());
          outstanding--; n_rsps++;
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        r.wr = bus.req_write; r.addr = bus.req_addr; r.data = bus.req_data; r.mask = bus.req_mask;
        exp_cmd.push_back(r);
        if (r.wr) exp_wdf.push_back(r);
        else begin exp_rsp.push_back(r.addr); outstanding++; n_reads++; end
        issued++;
      end
      tick();
      cyc++;
    end
    n_cmp++; if (cyc >= BOUND) begin n_err++; $display("FAIL rnd_timeout: got %0d cycles want < %0d", cyc, BOUND); end
    n_cmp++; if (n_rsps != n_reads || n_reads == 0) begin n_err++; $display("FAIL rnd_rsp_count: got %0d want %0d", n_rsps, n_reads); end
    idle_inputs();
  endtask

  initial begin
    calib = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_write(3, 0, 28'h0000100, {16{32'hDEADBEEF}}, '0);
    test_write(0, 2, AW'($urandom), rand_data(), {$urandom, $urandom});
    test_write(1, 1, AW'($urandom), rand_data(), {$urandom, $urandom});
    test_read();
    test_credit_limit();
    test_calib();
    test_reset_mid_wr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddr3_app_ctrl.md
Name: ddr3_app_ctrl

Overview:
Request-side controller that sits directly upstream of the DDR3 MIG wrapper and drives its native app_* interface. It accepts single-beat 512-bit read/write requests over a valid/ready port and sequences app_en/app_rdy and app_wdf_wren/app_wdf_rdy independently. Read data is returned over a back-pressurable response port. Reads are credit-gated so MIG read data, which cannot be stalled, always has buffer space.

Parameters:
ADDR_W, 28, app_addr width
DATA_W, 512, app data width (one BL8 burst, 4:1 mode, 64-bit DQ)
RSP_DEPTH, 8, response FIFO entries = max reads in flight; power of 2, >=2

Ports:
ui_clk  in  1  clock (MIG user clock)
ui_clk_sync_rst  in  1  synchronous active-high reset
init_calib_complete  in  1  MIG calibration done
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  MIG address
req_data  in  DATA_W  write data
req_mask  in  DATA_W/8  byte mask, 1=byte not written (MIG polarity)
rsp_valid  out  1  read data valid
rsp_ready  in  1  consumer ready
rsp_data  out  DATA_W  read data, in request order
app_addr  out  ADDR_W  to MIG
app_cmd  out  3  000 write, 001 read
app_en  out  1  command strobe
app_wdf_data  out  DATA_W  write data
app_wdf_mask  out  DATA_W/8  write mask
app_wdf_wren  out  1  write data strobe
app_wdf_end  out  1  last beat; always equals app_wdf_wren
app_rdy  in  1  MIG command accept
app_wdf_rdy  in  1  MIG write data accept
app_rd_data  in  DATA_W  MIG read data
app_rd_data_valid  in  1  MIG read data strobe
app_rd_data_end  in  1  ignored (single beat)

Behaviour:
- One clock; reset is synchronous and active-high: clock port ui_clk, reset port ui_clk_sync_rst.
- Reset values: req_ready=0, app_en=0, app_wdf_wren=0, app_wdf_end=0, rsp_valid=0, app_cmd=0, app_addr/data/mask=0; credit counter=0; FIFO empty; state IDLE.
- FSM IDLE, WR, RD.
- req_ready = (state==IDLE) && init_calib_complete && (credits < RSP_DEPTH). It does not depend on req_valid or req_write.
- IDLE: on accept in cycle N, register addr/data/mask/cmd. From cycle N+1, app_en=1. A write also sets app_wdf_wren=app_wdf_end=1 and goes to WR. A read increments credits and goes to RD.
- WR: app_en held until sampled with app_rdy=1, then drops next cycle. app_wdf_wren held until sampled with app_wdf_rdy=1, then drops next cycle. The two are tracked by independent done flags and may complete in either order or together. Return to IDLE the cycle after both are done, so the earliest next accept is N+2.
- RD: app_en held until app_rdy; then return to IDLE.
- Payload registers are stable while a strobe is asserted.
- app_rd_data_valid pushes app_rd_data into the response FIFO; rsp_valid follows in the next cycle (1-cycle latency).
- Pop on rsp_valid&&rsp_ready; rsp_data is first-word fall-through.
- credits: +1 on read accept, -1 on pop; on the same cycle, net 0. Credits never exceed RSP_DEPTH.
- A push into a full FIFO is impossible by construction. It is flagged by a simulation-only assertion; the data is dropped.
- Deassertion of init_calib_complete only blocks new accepts; an in-progress command completes.
- Reset mid-operation abandons the command; all state is cleared the following cycle.

Decomposition:
- Package ddr3_app_pkg: CMD_WRITE=3'b000, CMD_READ=3'b001, ADDR_W/DATA_W defaults, state enum.
- Sub-module ddr3_rsp_fifo: synchronous FWFT FIFO, parameterised width and depth, with count output.

Test Plan:
- Reset held 3 cycles with random inputs -> every output at its reset value; req_ready=1 the first cycle after release with calib=1.
- Write to addr 0x0000100, data 0xDEAD..., mask 0, app_rdy low 3 cycles, app_wdf_rdy=1 -> wren/end high 1 cycle, app_en high 4 cycles, cmd=000, req_ready low until both are done.
- Read addr 0x0000040, app_rdy=1; MIG returns 0xA5A5... 10 cycles later -> rsp_valid 1 cycle after rd_data_valid with identical data; credits return to 0 after pop.
- RSP_DEPTH=4, rsp_ready=0, issue 4 reads -> req_ready=0 after the 4th accept; 1 pop -> req_ready=1 the next cycle; order is preserved.
- init_calib_complete=0 with req_valid=1 -> req_ready=0, app_en never asserts; raise calib -> accepted the next cycle.
- Assert reset while in WR with app_wdf_rdy=0 -> app_en/app_wdf_wren=0 the next cycle, FSM in IDLE, credits=0.
